// File: rtl/writeback_arbiter.sv
// -----------------------------------------------------------------------------
// writeback_arbiter
//
// Purpose:
//   Last stage before the register-file write port. Completed results from the
//   ALU and the load unit arrive over valid/ready handshakes, each lands in a
//   one-entry buffer, and a fixed-priority arbiter (loads first) with a
//   starvation counter picks one entry per cycle to drive a registered write
//   (wr_enable / wr_address / wr_data). Writes aimed at x0 use their grant
//   slot but are never strobed into the register file.
//
// Parameters:
//   STARVE_LIMIT  consecutive lost-arbitration cycles after which a waiting
//                 ALU entry beats a waiting load entry (legal range 1..15).
//
// Ports:
//   clk                       system clock, all state on rising edge
//   reset                     synchronous, active-high
//   alu_valid/alu_rd/alu_data ALU result offer         (in)
//   alu_ready                 ALU buffer can accept     (out)
//   mem_valid/mem_rd/mem_data load result offer        (in)
//   mem_ready                 load buffer can accept    (out)
//   wr_enable/wr_address/wr_data  registered register-file write (out)
//   busy                      a buffer is occupied or a write is being driven
//
// Optional feature (compile-time macro WB_FORWARD_EN):
//   fwd_addr_a/fwd_addr_b (in)  read addresses to compare against the write
//   fwd_hit_a/fwd_hit_b   (out) write in flight targets that address
//   fwd_data_a/fwd_data_b (out) forwarded write data, 0 when no hit
//   With the macro undefined these ports do not exist.
//
// Handshake:
//   A transfer happens at a rising edge when x_valid && x_ready. x_ready is a
//   function of the buffer state and grant only (never of x_valid), so a
//   source may hold valid high and wait; x_ready = !x_full || grant_x, so a
//   buffer that drains at an edge can be refilled at that same edge.
// -----------------------------------------------------------------------------
module writeback_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
`ifdef WB_FORWARD_EN
  input  logic [4:0]  fwd_addr_a,
  input  logic [4:0]  fwd_addr_b,
  output logic        fwd_hit_a,
  output logic        fwd_hit_b,
  output logic [31:0] fwd_data_a,
  output logic [31:0] fwd_data_b,
`endif
  output logic        wr_enable,
  output logic [4:0]  wr_address,
  output logic [31:0] wr_data,
  output logic        busy
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic        alu_full_q, alu_full_d;
  logic [4:0]  alu_rd_q,   alu_rd_d;
  logic [31:0] alu_data_q, alu_data_d;

  logic        mem_full_q, mem_full_d;
  logic [4:0]  mem_rd_q,   mem_rd_d;
  logic [31:0] mem_data_q, mem_data_d;

  logic [3:0]  starve_cnt_q, starve_cnt_d;

  logic        wr_enable_q,  wr_enable_d;
  logic [4:0]  wr_address_q, wr_address_d;
  logic [31:0] wr_data_q,    wr_data_d;

  // ---------------------------------------------------------------------------
  // Arbitration: depends only on buffer flags and the starvation counter.
  // ---------------------------------------------------------------------------
  logic        grant_alu;
  logic        grant_mem;
  logic        grant_any;
  logic        alu_take;
  logic        mem_take;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;

  always_comb begin
    grant_alu = alu_full_q && (!mem_full_q || (starve_cnt_q == LIMIT));
    grant_mem = mem_full_q && !grant_alu;
    grant_any = grant_alu || grant_mem;
  end

  // Readies are forced low during reset so nothing is accepted while the
  // buffers are being cleared.
  always_comb begin
    alu_ready = !reset && (!alu_full_q || grant_alu);
    mem_ready = !reset && (!mem_full_q || grant_mem);
    alu_take  = alu_valid && alu_ready;
    mem_take  = mem_valid && mem_ready;
  end

  always_comb begin
    sel_rd   = grant_alu ? alu_rd_q   : mem_rd_q;
    sel_data = grant_alu ? alu_data_q : mem_data_q;
  end

  // ---------------------------------------------------------------------------
  // Buffer next state. Drain first, then a same-edge refill overrides it.
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_full_d = alu_full_q;
    alu_rd_d   = alu_rd_q;
    alu_data_d = alu_data_q;
    if (grant_alu) begin
      alu_full_d = 1'b0;
    end
    if (alu_take) begin
      alu_full_d = 1'b1;
      alu_rd_d   = alu_rd;
      alu_data_d = alu_data;
    end
  end

  always_comb begin
    mem_full_d = mem_full_q;
    mem_rd_d   = mem_rd_q;
    mem_data_d = mem_data_q;
    if (grant_mem) begin
      mem_full_d = 1'b0;
    end
    if (mem_take) begin
      mem_full_d = 1'b1;
      mem_rd_d   = mem_rd;
      mem_data_d = mem_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Starvation counter: counts edges where the ALU entry waits and loses.
  // Any edge with an empty ALU buffer or an ALU grant clears it.
  // ---------------------------------------------------------------------------
  always_comb begin
    starve_cnt_d = 4'd0;
    if (alu_full_q && !grant_alu) begin
      starve_cnt_d = (starve_cnt_q == LIMIT) ? starve_cnt_q : starve_cnt_q + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register. An x0 entry still consumes its grant but produces a
  // zeroed, non-strobed write. Without a grant, address/data hold.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_enable_d  = 1'b0;
    wr_address_d = wr_address_q;
    wr_data_d    = wr_data_q;
    if (grant_any) begin
      if (sel_rd != 5'd0) begin
        wr_enable_d  = 1'b1;
        wr_address_d = sel_rd;
        wr_data_d    = sel_data;
      end else begin
        wr_address_d = 5'd0;
        wr_data_d    = 32'd0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_full_q   <= 1'b0;
      alu_rd_q     <= 5'd0;
      alu_data_q   <= 32'd0;
      mem_full_q   <= 1'b0;
      mem_rd_q     <= 5'd0;
      mem_data_q   <= 32'd0;
      starve_cnt_q <= 4'd0;
      wr_enable_q  <= 1'b0;
      wr_address_q <= 5'd0;
      wr_data_q    <= 32'd0;
    end else begin
      alu_full_q   <= alu_full_d;
      alu_rd_q     <= alu_rd_d;
      alu_data_q   <= alu_data_d;
      mem_full_q   <= mem_full_d;
      mem_rd_q     <= mem_rd_d;
      mem_data_q   <= mem_data_d;
      starve_cnt_q <= starve_cnt_d;
      wr_enable_q  <= wr_enable_d;
      wr_address_q <= wr_address_d;
      wr_data_q    <= wr_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign wr_enable  = wr_enable_q;
  assign wr_address = wr_address_q;
  assign wr_data    = wr_data_q;
  assign busy       = alu_full_q || mem_full_q || wr_enable_q;

`ifdef WB_FORWARD_EN
  // Bypass for the cycle in which the register-file read still returns the
  // old value: compare read addresses against the write being driven now.
  always_comb begin
    fwd_hit_a  = wr_enable_q && (wr_address_q == fwd_addr_a) && (fwd_addr_a != 5'd0);
    fwd_hit_b  = wr_enable_q && (wr_address_q == fwd_addr_b) && (fwd_addr_b != 5'd0);
    fwd_data_a = fwd_hit_a ? wr_data_q : 32'd0;
    fwd_data_b = fwd_hit_b ? wr_data_q : 32'd0;
  end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

  localparam int LIMIT = 3;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        wr_enable;
  logic [4:0]  wr_address;
  logic [31:0] wr_data;
  logic        busy;
`ifdef WB_FORWARD_EN
  logic [4:0]  fwd_addr_a;
  logic [4:0]  fwd_addr_b;
  logic        fwd_hit_a;
  logic        fwd_hit_b;
  logic [31:0] fwd_data_a;
  logic [31:0] fwd_data_b;
`endif

  always #5 clk = ~clk;

  writeback_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .mem_valid  (mem_valid),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
`ifdef WB_FORWARD_EN
    .fwd_addr_a (fwd_addr_a),
    .fwd_addr_b (fwd_addr_b),
    .fwd_hit_a  (fwd_hit_a),
    .fwd_hit_b  (fwd_hit_b),
    .fwd_data_a (fwd_data_a),
    .fwd_data_b (fwd_data_b),
`endif
    .wr_enable  (wr_enable),
    .wr_address (wr_address),
    .wr_data    (wr_data),
    .busy       (busy)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int tests  = 0;
  int errors = 0;
  logic [4:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
    mem_valid = mv;
    mem_rd    = mrd;
    mem_data  = md;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic check_outs(input string tag, input logic ea, input logic em, input logic ew,
                            input logic [4:0] waddr, input logic [31:0] wdata, input logic eb);
    check({tag, "_alu_ready"}, alu_ready, ea);
    check({tag, "_mem_ready"}, mem_ready, em);
    check({tag, "_wr_enable"}, wr_enable, ew);
    check({tag, "_wr_address"}, wr_address, waddr);
    check({tag, "_wr_data"}, wr_data, wdata);
    check({tag, "_busy"}, busy, eb);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table: one row per cycle, inputs applied in that cycle and
  // the outputs expected during that same cycle (before its closing edge).
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        ea_rdy;
    logic        em_rdy;
    logic        e_wen;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_busy;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs[NVEC];

  function automatic vec_t mk(logic av, logic [4:0] ard, logic [31:0] ad,
                              logic mv, logic [4:0] mrd, logic [31:0] md,
                              logic ea, logic em, logic ew, logic [4:0] wa,
                              logic [31:0] wd, logic eb);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad;
    v.mv = mv; v.mrd = mrd; v.md = md;
    v.ea_rdy = ea; v.em_rdy = em; v.e_wen = ew;
    v.e_waddr = wa; v.e_wdata = wd; v.e_busy = eb;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: each buffer is a queue holding at most one entry; the
  // arbiter rule and the write it produces are taken straight from the rules
  // for who wins and what an issued entry looks like.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        ma_q[$];
  ent_t        mm_q[$];
  int          m_lost;
  logic        m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  // 0: nobody, 1: ALU, 2: load
  function automatic int model_winner();
    if (ma_q.size() > 0 && (mm_q.size() == 0 || m_lost == LIMIT)) return 1;
    if (mm_q.size() > 0) return 2;
    return 0;
  endfunction

  task automatic model_edge(input int win, input logic era, input logic erm);
    ent_t e;
    bit   alu_waiting;
    if (reset) begin
      ma_q.delete();
      mm_q.delete();
      m_lost  = 0;
      m_wen   = 1'b0;
      m_waddr = 5'd0;
      m_wdata = 32'd0;
    end else begin
      alu_waiting = (ma_q.size() > 0);
      if (win != 0) begin
        if (win == 1) e = ma_q.pop_front();
        else          e = mm_q.pop_front();
        m_wen   = (e.rd != 5'd0);
        m_waddr = e.rd;
        m_wdata = (e.rd != 5'd0) ? e.data : 32'd0;
      end else begin
        m_wen = 1'b0;
      end
      if (alu_waiting && win != 1) m_lost = (m_lost + 1 > LIMIT) ? LIMIT : m_lost + 1;
      else                         m_lost = 0;
      if (alu_valid && era) ma_q.push_back({alu_rd, alu_data});
      if (mem_valid && erm) mm_q.push_back({mem_rd, mem_data});
    end
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int   win;
    logic era, erm;
    logic [4:0] exp_addr;
    int   c;

`ifdef WB_FORWARD_EN
    fwd_addr_a = 5'd0;
    fwd_addr_b = 5'd0;
`endif

    // --- Reset held 2 cycles with both sources offering ----------------------
    reset = 1'b1;
    drive(1'b1, 5'd3, 32'h1234_0001, 1'b1, 5'd4, 32'h1234_0002);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      check_outs("reset_hold", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    end
    @(negedge clk);
    reset = 1'b0;
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      check_outs("reset_release", 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
      @(negedge clk);
    end

    // --- Directed table ------------------------------------------------------
    vecs[0]  = mk(1, 5'hA, 32'hABCDEFAB, 0, 5'h0, 32'h0,        1, 1, 0, 5'h0, 32'h0,        0);
    vecs[1]  = mk(0, 5'h0, 32'h0,        0, 5'h0, 32'h0,        1, 1, 0, 5'h0, 32'h0,        1);
    vecs[2]  = mk(0, 5'h0, 32'h0,        0, 5'h0, 32'h0,        1, 1, 1, 5'hA, 32'hABCDEFAB, 1);
    vecs[3]  = mk(0, 5'h0, 32'h0,        0, 5'h0, 32'h0,        1, 1, 0, 5'hA, 32'hABCDEFAB, 0);
    vecs[4]  = mk(0, 5'h0, 32'h0,        1, 5'h0, 32'hEEEEEEEE, 1, 1, 0, 5'hA, 32'hABCDEFAB, 0);
    vecs[5]  = mk(0, 5'h0, 32'h0,        0, 5'h0, 32'h0,        1, 1, 0, 5'hA, 32'hABCDEFAB, 1);
    vecs[6]  = mk(0, 5'h0, 32'h0,        0, 5'h0, 32'h0,        1, 1, 0, 5'h0, 32'h0,        0);
    vecs[7]  = mk(0, 5'h0, 32'h0,        0, 5'h0, 32'h0,        1, 1, 0, 5'h0, 32'h0,        0);
    vecs[8]  = mk(1, 5'h3, 32'h11111111, 1, 5'h4, 32'h22222222, 1, 1, 0, 5'h0, 32'h0,        0);
    vecs[9]  = mk(0, 5'h0, 32'h0,        0, 5'h0, 32'h0,        0, 1, 0, 5'h0, 32'h0,        1);
    vecs[10] = mk(0, 5'h0, 32'h0,        0, 5'h0, 32'h0,        1, 1, 1, 5'h4, 32'h22222222, 1);
    vecs[11] = mk(0, 5'h0, 32'h0,        0, 5'h0, 32'h0,        1, 1, 1, 5'h3, 32'h11111111, 1);
    vecs[12] = mk(0, 5'h0, 32'h0,        0, 5'h0, 32'h0,        1, 1, 0, 5'h3, 32'h11111111, 0);

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].mv, vecs[i].mrd, vecs[i].md);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].ea_rdy, vecs[i].em_rdy, vecs[i].e_wen,
                 vecs[i].e_waddr, vecs[i].e_wdata, vecs[i].e_busy);
      @(negedge clk);
    end
    idle();

    // --- Contention: both valid for 8 cycles ---------------------------------
    exp_q = '{5'd2, 5'd2, 5'd2, 5'd1, 5'd2, 5'd2, 5'd2, 5'd1};
    c = 0;
    while (exp_q.size() > 0 && c < 40) begin
      if (c < 8) drive(1'b1, 5'd1, 32'hA000_0000 + c, 1'b1, 5'd2, 32'hB000_0000 + c);
      else       idle();
      #1;
      if (c == 0)           check("contend_alu_ready_c0", alu_ready, 1'b1);
      if (c >= 1 && c <= 7) check($sformatf("contend_alu_ready_c%0d", c), alu_ready, (c == 4));
      if (wr_enable) begin
        exp_addr = exp_q.pop_front();
        check("contend_wr_address", wr_address, exp_addr);
        check("contend_wr_data_src", wr_data[31:28], (exp_addr == 5'd1) ? 4'hA : 4'hB);
      end
      @(negedge clk);
      c++;
    end
    check("contend_missing_writes", exp_q.size(), 0);
    idle();
    repeat (6) @(negedge clk);
    #1;
    check("contend_drained_busy", busy, 1'b0);
    @(negedge clk);

    // --- Mid-operation reset -------------------------------------------------
    drive(1'b1, 5'd7, 32'h7777_7777, 1'b1, 5'd9, 32'h9999_9999);
    @(negedge clk);
    reset = 1'b1;
    idle();
    #1;
    check("midreset_busy_before", busy, 1'b1);
    check("midreset_alu_ready", alu_ready, 1'b0);
    check("midreset_mem_ready", mem_ready, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset_busy_after", busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("midreset_no_write%0d", i), wr_enable, 1'b0);
      @(negedge clk); #1;
    end
    @(negedge clk);

`ifdef WB_FORWARD_EN
    // --- Forwarding ----------------------------------------------------------
    fwd_addr_a = 5'd5;
    fwd_addr_b = 5'd0;
    drive(1'b1, 5'h5, 32'h12345678, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    idle();
    @(negedge clk); #1;
    check("fwd_wr_enable", wr_enable, 1'b1);
    check("fwd_hit_a", fwd_hit_a, 1'b1);
    check("fwd_data_a", fwd_data_a, 32'h12345678);
    check("fwd_hit_b", fwd_hit_b, 1'b0);
    check("fwd_data_b", fwd_data_b, 32'd0);
    @(negedge clk); #1;
    check("fwd_hit_a_after", fwd_hit_a, 1'b0);
    fwd_addr_a = 5'd0;
    @(negedge clk);
`endif

    // --- Randomized run against the reference model --------------------------
    reset = 1'b1;
    idle();
    ma_q.delete();
    mm_q.delete();
    m_lost  = 0;
    m_wen   = 1'b0;
    m_waddr = 5'd0;
    m_wdata = 32'd0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 149) == 0);
      drive($urandom_range(0, 99) < 70,
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
            $urandom,
            $urandom_range(0, 99) < 70,
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
            $urandom);
      #1;
      win = model_winner();
      era = !reset && (ma_q.size() == 0 || win == 1);
      erm = !reset && (mm_q.size() == 0 || win == 2);
      check_outs("rand", era, erm, m_wen, m_waddr, m_wdata,
                 (ma_q.size() > 0) || (mm_q.size() > 0) || m_wen);
      model_edge(win, era, erm);
    end
    @(negedge clk);
    reset = 1'b0;
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Writeback stage that sits directly upstream of the register file's write port. Accepts completed results from the ALU and the load unit over valid/ready handshakes, holds each in a one-entry buffer, arbitrates between them and drives a single registered write (wr_enable, wr_address, wr_data) into the register file each cycle. Loads win by default. A starvation counter guarantees ALU progress. Writes targeting x0 are consumed but never issued.

## Interface
- STARVE_LIMIT, 3: consecutive lost-arbitration cycles after which the ALU entry takes priority; legal range 1–15.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result offered.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result value.
- alu_ready  out  1  ALU buffer can accept this cycle.
- mem_valid  in  1  load result offered.
- mem_rd  in  5  load destination register.
- mem_data  in  32  load result value.
- mem_ready  out  1  load buffer can accept this cycle.
- wr_enable  out  1  register-file write strobe; registered.
- wr_address  out  5  register-file write address; registered.
- wr_data  out  32  register-file write data; registered.
- busy  out  1  either buffer occupied or wr_enable high.

## Operation
- Per source, a one-entry buffer {full, rd, data}. A transfer occurs at a rising edge when valid && ready.
- Grant is combinational from buffer flags and the starvation counter only. It never depends on the valid inputs.
  - Only one buffer full: that buffer is granted.
  - Both full and starve_cnt == STARVE_LIMIT: ALU is granted.
  - Both full otherwise: load (mem) is granted.
- x_ready = !x_full || grant_x. A source can refill in the same edge its buffer drains, giving throughput of 1 per cycle per source when uncontested.
- On a granted edge, the output register loads the granted entry's rd and data.
  - wr_enable = 1 if rd != 0.
  - If rd == 0, wr_enable = 0 and wr_address/wr_data = 0. The x0 write is dropped but still consumes the grant slot.
- No grant: wr_enable = 0 next cycle. wr_address and wr_data hold their previous values.
- starve_cnt, width 4:
  - increments, saturating at STARVE_LIMIT, on each edge where the ALU buffer is full and not granted;
  - clears to 0 on an ALU grant, or when the ALU buffer is empty.
- Reset: both buffers empty, wr_enable = 0, wr_address = 0, wr_data = 0, starve_cnt = 0, busy = 0. While reset is high, alu_ready = mem_ready = 0 and inputs are ignored. Reset asserted mid-operation discards buffered entries and any pending write.

## Timing
- Accept at edge E0 → buffer full during cycle 1 → if granted, output register loaded at E1 → wr_enable high during cycle 2 → register file updated at E2. Total 2 cycles from handshake to output strobe.
- Back-to-back from one uncontested source: wr_enable high every cycle.
- Both sources valid every cycle, STARVE_LIMIT = 3: issue order is mem, mem, mem, alu, repeating.
- Simultaneous drain and refill of the same buffer at one edge is legal. The new entry is eligible for grant next cycle.
- Same rd from both sources in flight: issue order follows grant order. No merging.

## Configuration
- WB_FORWARD_EN defined: adds ports fwd_addr_a/fwd_addr_b (in, 5) and fwd_hit_a/fwd_hit_b (out, 1), fwd_data_a/fwd_data_b (out, 32).
  - fwd_hit_x = wr_enable && wr_address == fwd_addr_x && fwd_addr_x != 0.
  - fwd_data_x = wr_data when hit, else 0.
  - Purely combinational from the output register. Covers the cycle in which the register file read still returns the old value.
- WB_FORWARD_EN undefined: those ports do not exist. No other behaviour changes.

## Test plan
- Reset: hold reset 2 cycles with alu_valid = mem_valid = 1 → readies 0, wr_enable 0, wr_address 0, wr_data 0, busy 0; nothing issued after release from those cycles.
- Single ALU write: alu_rd = 5'hA, alu_data = 32'hABCDEFAB accepted at E0 → wr_enable = 1, wr_address = 5'hA, wr_data = 32'hABCDEFAB during cycle 2 only.
- x0 drop: mem_rd = 0, mem_data = 32'hEEEEEEEE accepted → wr_enable stays 0 for the whole sequence; mem_ready returns to 1.
- Contention: both sources valid for 8 cycles (alu_rd = 1, mem_rd = 2), STARVE_LIMIT = 3 → wr_address sequence 2, 2, 2, 1, 2, 2, 2, 1; alu_ready low while its buffer waits.
- Mid-operation reset: both buffers full, reset pulsed 1 cycle → no write from those entries appears; busy = 0 the cycle after reset.
- WB_FORWARD_EN: write rd = 5'h5, data = 32'h12345678 with fwd_addr_a = 5 and fwd_addr_b = 0 → fwd_hit_a = 1 with data 32'h12345678 in the wr_enable cycle; fwd_hit_b = 0.
